// File: rtl/tdc_hit_encoder.sv
`default_nettype none
//==============================================================================
// Module   : tdc_hit_encoder
// Purpose  : Encodes sampler edge vectors into coarse/fine tagged hits and
//            buffers them in a show-ahead FIFO with overflow accounting.
// Revision : 1.0
//==============================================================================
module tdc_hit_encoder #(
    parameter int LENGTH   = 8,
    parameter int FINE_W   = 5,
    parameter int COARSE_W = 16,
    parameter int DEPTH    = 8
) (
    input  logic                         clk,
    input  logic                         clr1,
    input  logic                         enable,
    input  logic [4*LENGTH-1:0]          fine_vec,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [COARSE_W+FINE_W:0]     out_data,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic [7:0]                   overflow_cnt
);

    localparam int c_vec_w   = 4 * LENGTH;
    localparam int c_word_w  = 1 + COARSE_W + FINE_W;
    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_level_w = c_ptr_w + 1;

    localparam logic [c_vec_w-1:0]   c_vec_one = c_vec_w'(1);
    localparam logic [c_level_w-1:0] c_full    = c_level_w'(DEPTH);

    logic [COARSE_W-1:0]  r_coarse;
    logic [c_vec_w-1:0]   r_s1_vec;
    logic [COARSE_W-1:0]  r_s1_coarse;
    logic                 r_s2_hit;
    logic [c_word_w-1:0]  r_s2_word;

    logic [c_word_w-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wptr;
    logic [c_ptr_w-1:0]   r_rptr;
    logic [c_level_w-1:0] r_level;
    logic [7:0]           r_ovf;

    logic                 w_hit;
    logic                 w_multi;
    logic [FINE_W-1:0]    w_fine;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_drop;

    // Free-running coarse time base; gated by enable.
    always_ff @(posedge clk or posedge clr1) begin
        if (clr1) begin
            r_coarse <= '0;
        end else if (enable) begin
            r_coarse <= r_coarse + COARSE_W'(1);
        end
    end

    // Stage 1: capture the raw vector with the pre-increment coarse tag.
    always_ff @(posedge clk or posedge clr1) begin
        if (clr1) begin
            r_s1_vec    <= '0;
            r_s1_coarse <= '0;
        end else begin
            r_s1_vec    <= enable ? fine_vec : '0;
            r_s1_coarse <= r_coarse;
        end
    end

    // Lowest set bit wins: scanning downward leaves the smallest index last.
    always_comb begin
        w_fine = '0;
        for (int i = c_vec_w - 1; i >= 0; i--) begin
            if (r_s1_vec[i]) begin
                w_fine = FINE_W'(i);
            end
        end
    end

    assign w_hit   = |r_s1_vec;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(r_s1_vec & (r_s1_vec - c_vec_one));

    // Stage 2: registered tagged hit.
    always_ff @(posedge clk or posedge clr1) begin
        if (clr1) begin
            r_s2_hit  <= 1'b0;
            r_s2_word <= '0;
        end else begin
            r_s2_hit  <= w_hit;
            r_s2_word <= {w_multi, r_s1_coarse, w_fine};
        end
    end

    assign w_full = (r_level == c_full);
    assign w_pop  = out_valid & out_ready;
    assign w_push = r_s2_hit & (~w_full | w_pop);
    assign w_drop = r_s2_hit & w_full & ~w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_s2_word;
        end
    end

    always_ff @(posedge clk or posedge clr1) begin
        if (clr1) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_w'(1);
            end
        end
    end

    // Occupancy kept as its own counter so full and empty stay distinct.
    always_ff @(posedge clk or posedge clr1) begin
        if (clr1) begin
            r_level <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_level_w'(1);
                2'b01:   r_level <= r_level - c_level_w'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr1) begin
        if (clr1) begin
            r_ovf <= '0;
        end else if (w_drop && (r_ovf != 8'hFF)) begin
            r_ovf <= r_ovf + 8'd1;
        end
    end

    assign out_valid    = (r_level != '0);
    assign out_data     = out_valid ? r_mem[r_rptr] : '0;
    assign fifo_level   = r_level;
    assign overflow_cnt = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_tdc_hit_encoder.sv
`default_nettype none
//==============================================================================
// Module   : tb_tdc_hit_encoder
// Purpose  : Self-checking bench: vector table, directed corners, random run.
// Revision : 1.0
//==============================================================================
module tb_tdc_hit_encoder;

    logic        clk;
    logic        clr1;
    logic        enable;
    logic [31:0] fine_vec;
    logic        out_valid;
    logic        out_ready;
    logic [21:0] out_data;
    logic [3:0]  fifo_level;
    logic [7:0]  overflow_cnt;

    tdc_hit_encoder #(
        .LENGTH  (8),
        .FINE_W  (5),
        .COARSE_W(16),
        .DEPTH   (8)
    ) dut (
        .clk         (clk),
        .clr1        (clr1),
        .enable      (enable),
        .fine_vec    (fine_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .fifo_level  (fifo_level),
        .overflow_cnt(overflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit          v;
        logic [21:0] w;
    } rec_t;

    typedef struct {
        logic [31:0] vec;
        logic [4:0]  fine;
        logic        multi;
    } vec_t;

    rec_t        dl[$];
    logic [21:0] fq[$];
    int          m_coarse;
    int          m_ovf;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        rec_t e;
        e.v = 1'b0;
        e.w = '0;
        dl.delete();
        dl.push_back(e);
        dl.push_back(e);
        fq.delete();
        m_coarse = 0;
        m_ovf    = 0;
    endfunction

    // One clock edge of the intended behaviour, from the inputs held across it.
    function automatic void model_edge();
        rec_t  old;
        rec_t  nw;
        bit    full;
        bit    pop;
        int    low;
        if (clr1) begin
            model_reset();
            return;
        end
        old  = dl.pop_front();
        full = (fq.size() == 8);
        pop  = (fq.size() > 0) && out_ready;
        if (pop) void'(fq.pop_front());
        if (old.v) begin
            if (!full || pop) fq.push_back(old.w);
            else if (m_ovf < 255) m_ovf++;
        end
        low = 0;
        for (int i = 31; i >= 0; i--) if (fine_vec[i]) low = i;
        nw.v = enable && (fine_vec != 0);
        nw.w = {($countones(fine_vec) >= 2), m_coarse[15:0], low[4:0]};
        dl.push_back(nw);
        if (enable) m_coarse = (m_coarse + 1) % 65536;
    endfunction

    function automatic void check_all();
        chk("valid", out_valid, fq.size() != 0);
        chk("data", out_data, (fq.size() != 0) ? fq[0] : 22'd0);
        chk("level", fifo_level, fq.size());
        chk("ovf", overflow_cnt, m_ovf);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        clr1 = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow_cnt, 0);
        ticks(2);
        clr1 = 1'b0;
    endtask

    vec_t tbl[9];

    initial begin
        logic [15:0] c0;
        logic [15:0] ch;
        int          guard;

        tbl[0] = '{32'h0000_0001, 5'd0,  1'b0};
        tbl[1] = '{32'h0000_0400, 5'd10, 1'b0};
        tbl[2] = '{32'h0000_0090, 5'd4,  1'b1};
        tbl[3] = '{32'h8000_0000, 5'd31, 1'b0};
        tbl[4] = '{32'h8000_0001, 5'd0,  1'b1};
        tbl[5] = '{32'h0001_0000, 5'd16, 1'b0};
        tbl[6] = '{32'hFFFF_FFFF, 5'd0,  1'b1};
        tbl[7] = '{32'h0000_F000, 5'd12, 1'b1};
        tbl[8] = '{32'h4000_0000, 5'd30, 1'b0};

        clr1      = 1'b1;
        enable    = 1'b0;
        fine_vec  = '0;
        out_ready = 1'b0;
        do_reset();

        // Idle run, then a hit should carry coarse tag 20.
        enable = 1'b1;
        ticks(20);
        chk("idle_level", fifo_level, 0);
        fine_vec = 32'h0000_0400;
        tick();
        fine_vec = '0;
        tick();
        tick();
        chk("idle20_tag", out_data, {1'b0, 16'd20, 5'd10});

        // Single hit at coarse 5 with exact latency.
        do_reset();
        enable = 1'b1;
        ticks(5);
        fine_vec = 32'h0000_0400;
        tick();
        fine_vec = '0;
        tick();
        chk("single_nobypass", out_valid, 0);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, {1'b0, 16'd5, 5'd10});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_popped", fifo_level, 0);

        // Encoder table.
        for (int i = 0; i < 9; i++) begin
            c0 = m_coarse[15:0];
            fine_vec = tbl[i].vec;
            tick();
            fine_vec = '0;
            tick();
            chk("tbl_nobypass", out_valid, 0);
            tick();
            chk("tbl_fine", out_data[4:0], tbl[i].fine);
            chk("tbl_multi", out_data[21], tbl[i].multi);
            chk("tbl_coarse", out_data[20:5], c0);
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Overflow: DEPTH+3 hits without reads.
        c0 = m_coarse[15:0];
        fine_vec = 32'h1;
        ticks(11);
        fine_vec = '0;
        ticks(2);
        chk("ovf_level", fifo_level, 8);
        chk("ovf_count", overflow_cnt, 3);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain_valid", out_valid, 1);
            chk("ovf_drain_coarse", out_data[20:5], c0 + 16'(i));
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        chk("ovf_empty", fifo_level, 0);

        // Full with a simultaneous pop accepts the write.
        fine_vec = 32'h1;
        ticks(8);
        fine_vec = '0;
        ticks(2);
        chk("full_level", fifo_level, 8);
        ch = m_coarse[15:0];
        fine_vec = 32'h8;
        tick();
        fine_vec = '0;
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fullpop_level", fifo_level, 8);
        chk("fullpop_ovf", overflow_cnt, 3);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                chk("fullpop_tail_fine", out_data[4:0], 5'd3);
                chk("fullpop_tail_coarse", out_data[20:5], ch);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        // Random traffic, including enable drops mid-stream.
        for (int i = 0; i < 1500; i++) begin
            enable    = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: fine_vec = '0;
                4, 5, 6:    fine_vec = 32'h1 << $urandom_range(0, 31);
                default:    fine_vec = $urandom;
            endcase
            tick();
        end
        enable    = 1'b1;
        fine_vec  = '0;
        out_ready = 1'b1;
        ticks(12);
        out_ready = 1'b0;
        chk("rand_drained", fifo_level, 0);

        // Coarse wrap: tags FFFF then 0000 on consecutive hits.
        guard = 0;
        while (m_coarse != 16'hFFFF && guard < 70000) begin
            tick();
            guard++;
        end
        fine_vec = 32'h1;
        tick();
        fine_vec = 32'h2;
        tick();
        fine_vec = '0;
        ticks(2);
        chk("wrap_first", out_data[20:5], 16'hFFFF);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("wrap_second", out_data[20:5], 16'h0000);
        chk("wrap_second_fine", out_data[4:0], 5'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Asynchronous clear with entries buffered.
        fine_vec = 32'h10;
        ticks(3);
        fine_vec = '0;
        ticks(2);
        chk("preclr_level", fifo_level, 3);
        #2;
        clr1 = 1'b1;
        model_reset();
        #1;
        chk("clr_valid", out_valid, 0);
        chk("clr_level", fifo_level, 0);
        chk("clr_ovf", overflow_cnt, 0);
        chk("clr_data", out_data, 0);
        tick();
        clr1 = 1'b0;
        ticks(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
